// File: rtl/wallace_cpa_pipe_if.sv
// -----------------------------------------------------------------------------
// wallace_cpa_pipe_if
// Bundle of the operand handshake (upstream side) and result handshake
// (downstream side) of the Wallace-tree carry-propagate pipeline.
//   i_valid / o_ready              : operand handshake
//   i_final_sum / i_final_carry    : redundant rows from the reduction tree
//   o_valid / i_ready              : result handshake
//   o_product                      : (sum + carry) mod 2^NUM_COLS
//   o_msb, o_mant, o_guard, o_sticky : normalized mantissa fields
// Modports: master = environment (drives operands and i_ready),
//           slave  = the pipeline itself.
// -----------------------------------------------------------------------------
interface wallace_cpa_pipe_if #(
   parameter int N        = 24,
   parameter int NUM_COLS = 2 * N
);
   logic                i_valid;
   logic                o_ready;
   logic [NUM_COLS-1:0] i_final_sum;
   logic [NUM_COLS-1:0] i_final_carry;
   logic                o_valid;
   logic                i_ready;
   logic [NUM_COLS-1:0] o_product;
   logic                o_msb;
   logic [N-1:0]        o_mant;
   logic                o_guard;
   logic                o_sticky;

   modport master (
      output i_valid, i_final_sum, i_final_carry, i_ready,
      input  o_ready, o_valid, o_product, o_msb, o_mant, o_guard, o_sticky
   );

   modport slave (
      input  i_valid, i_final_sum, i_final_carry, i_ready,
      output o_ready, o_valid, o_product, o_msb, o_mant, o_guard, o_sticky
   );
endinterface

// File: rtl/wallace_cpa_pipe.sv
// -----------------------------------------------------------------------------
// wallace_cpa_pipe
// Two-stage carry-propagate adder for the final sum/carry rows of the FPU
// multiplier's Wallace tree. Stage 1 adds the low SPLIT columns and keeps the
// carry-out plus the raw high halves; stage 2 adds the high halves with that
// carry. The registered product is normalized combinationally into a
// mantissa, guard and sticky bit for the rounding logic.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset (clears the valid bits only)
//   bus    : wallace_cpa_pipe_if.slave (operand and result handshakes)
// -----------------------------------------------------------------------------
module wallace_cpa_pipe #(
   parameter int N        = 24,
   parameter int NUM_COLS = 2 * N,
   parameter int SPLIT    = N
) (
   input  logic                 i_clk,
   input  logic                 i_rst,
   wallace_cpa_pipe_if.slave    bus
);
   localparam int HI_W = NUM_COLS - SPLIT;
   localparam int M    = NUM_COLS - 1;

   logic                v1_reg;
   logic                v2_reg;
   logic [SPLIT-1:0]    r1_lo_reg;
   logic                r1_c_reg;
   logic [HI_W-1:0]     r1_sh_reg;
   logic [HI_W-1:0]     r1_ch_reg;
   logic [NUM_COLS-1:0] r2_prod_reg;

   logic                slot2_free;
   logic                stage1_free;
   logic                accept;
   logic                advance;
   logic [SPLIT:0]      lo_sum;
   logic [HI_W-1:0]     hi_sum;
   logic [NUM_COLS-1:0] norm;

   // Stage 2 can take data if empty or its result leaves this cycle; stage 1
   // can take data if empty or it empties into stage 2 this cycle, which
   // gives one result per cycle while the downstream keeps i_ready high.
   assign slot2_free  = !v2_reg || bus.i_ready;
   assign stage1_free = !v1_reg || slot2_free;
   assign accept      = bus.i_valid && stage1_free;
   assign advance     = v1_reg && slot2_free;

   assign bus.o_ready = stage1_free;
   assign bus.o_valid = v2_reg;

   // Low half with its carry-out in the extra top bit.
   assign lo_sum = {1'b0, bus.i_final_sum[SPLIT-1:0]}
                 + {1'b0, bus.i_final_carry[SPLIT-1:0]};

   // High half; carry out of the top column is dropped (mod 2^NUM_COLS).
   assign hi_sum = r1_sh_reg + r1_ch_reg + {{(HI_W-1){1'b0}}, r1_c_reg};

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         v1_reg <= 1'b0;
         v2_reg <= 1'b0;
      end else begin
         if (accept) begin
            v1_reg <= 1'b1;
         end else if (advance) begin
            v1_reg <= 1'b0;
         end

         if (advance) begin
            v2_reg <= 1'b1;
         end else if (v2_reg && bus.i_ready) begin
            v2_reg <= 1'b0;
         end
      end
   end

   // Datapath registers carry no reset; the valid bits qualify them.
   always_ff @(posedge i_clk) begin
      if (accept) begin
         r1_lo_reg <= lo_sum[SPLIT-1:0];
         r1_c_reg  <= lo_sum[SPLIT];
         r1_sh_reg <= bus.i_final_sum[NUM_COLS-1:SPLIT];
         r1_ch_reg <= bus.i_final_carry[NUM_COLS-1:SPLIT];
      end
      if (advance) begin
         r2_prod_reg <= {hi_sum, r1_lo_reg};
      end
   end

   // Normalization: when the top bit is clear, shift left by one so the
   // leading one sits at M. The zero shifted into bit 0 keeps the sticky
   // range correct for both cases with a single OR-reduction.
   assign norm = r2_prod_reg[M] ? r2_prod_reg : (r2_prod_reg << 1);

   assign bus.o_product = r2_prod_reg;
   assign bus.o_msb     = r2_prod_reg[M];
   assign bus.o_mant    = norm[M -: N];
   assign bus.o_guard   = norm[M-N];
   assign bus.o_sticky  = |norm[M-N-1:0];

endmodule

// File: tb/tb_wallace_cpa_pipe.sv
module tb_wallace_cpa_pipe;
   localparam int N  = 24;
   localparam int NC = 2 * N;

   typedef struct {
      logic [NC-1:0] prod;
      logic          msb;
      logic [N-1:0]  mant;
      logic          guard;
      logic          sticky;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   wallace_cpa_pipe_if #(.N(N), .NUM_COLS(NC)) bus ();

   wallace_cpa_pipe #(.N(N), .NUM_COLS(NC), .SPLIT(N)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   exp_t          q[$];
   int            total = 0;
   int            bad = 0;
   int            results = 0;
   bit            held_valid = 0;
   logic [NC-1:0] held_prod;
   logic [N-1:0]  held_mant;
   logic          held_guard;
   logic          held_sticky;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Reference: plain integer addition, then locate the leading bit
   // arithmetically and split the remainder into guard and sticky.
   function automatic exp_t model(logic [NC-1:0] s, logic [NC-1:0] c);
      exp_t e;
      longint unsigned p, top, gw;
      top = 64'd1 << (NC - 1);
      p = (64'(s) + 64'(c)) % (top * 2);
      e.prod = NC'(p);
      if (p >= top) begin
         gw = 64'd1 << (NC - N - 1);      // weight of the guard bit
         e.msb = 1'b1;
      end else begin
         gw = 64'd1 << (NC - N - 2);
         e.msb = 1'b0;
      end
      e.mant   = N'(p / (gw * 2));
      e.guard  = ((p / gw) % 2) == 1;
      e.sticky = (p % gw) != 0;
      return e;
   endfunction

   function automatic logic [NC-1:0] rnd_row();
      logic [63:0] r;
      int unsigned mode;
      mode = $urandom_range(0, 7);
      r = {$urandom(), $urandom()};
      if (mode == 0) r = '1;
      else if (mode == 1) r = '0;
      else if (mode == 2) r = 64'd1 << $urandom_range(0, NC - 1);
      return NC'(r);
   endfunction

   // Monitor: compares whenever a result is handed over, checks stall
   // stability and the ready/valid relationship against pipeline occupancy.
   always @(negedge clk) begin
      if (rst) begin
         held_valid = 0;
      end else begin
         chk("o_ready", 64'(bus.o_ready), 64'(!(q.size() == 2 && !bus.i_ready)));
         if (q.size() == 0) chk("o_valid_idle", 64'(bus.o_valid), 64'd0);
         if (held_valid) begin
            chk("stall_product", 64'(bus.o_product), 64'(held_prod));
            chk("stall_mant", 64'(bus.o_mant), 64'(held_mant));
            chk("stall_guard", 64'(bus.o_guard), 64'(held_guard));
            chk("stall_sticky", 64'(bus.o_sticky), 64'(held_sticky));
         end
         if (bus.o_valid && bus.i_ready) begin
            held_valid = 0;
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_result: got %h expected none", bus.o_product);
            end else begin
               exp_t e;
               e = q.pop_front();
               results++;
               chk("product", 64'(bus.o_product), 64'(e.prod));
               chk("msb", 64'(bus.o_msb), 64'(e.msb));
               chk("mant", 64'(bus.o_mant), 64'(e.mant));
               chk("guard", 64'(bus.o_guard), 64'(e.guard));
               chk("sticky", 64'(bus.o_sticky), 64'(e.sticky));
               $display("result %0d: product=%h mant=%h g=%0b s=%0b",
                        results, bus.o_product, bus.o_mant, bus.o_guard, bus.o_sticky);
            end
         end else if (bus.o_valid) begin
            held_valid  = 1;
            held_prod   = bus.o_product;
            held_mant   = bus.o_mant;
            held_guard  = bus.o_guard;
            held_sticky = bus.o_sticky;
         end else begin
            held_valid = 0;
         end
      end
   end

   // One clock of stimulus; called at posedge+1, returns at posedge+1.
   task automatic step(output bit acc);
      @(negedge clk);
      acc = bus.i_valid && bus.o_ready && !rst;
      @(posedge clk);
      if (acc) q.push_back(model(bus.i_final_sum, bus.i_final_carry));
      #1;
   endtask

   task automatic send(input logic [NC-1:0] s, input logic [NC-1:0] c);
      bit acc;
      int n;
      n = 0;
      bus.i_valid       = 1'b1;
      bus.i_final_sum   = s;
      bus.i_final_carry = c;
      do begin
         step(acc);
         n++;
      end while (!acc && n < 100);
      chk("send_accepted", 64'(acc), 64'd1);
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      bus.i_valid = 1'b0;
      bus.i_ready = 1'b1;
      do begin
         step(acc);
         n++;
      end while (q.size() > 0 && n < 100);
      chk("drain_empty", 64'(q.size()), 64'd0);
   endtask

   initial begin
      bit acc;
      int idx, cyc, accepted, r0;
      bit seen;
      logic [NC-1:0] ss[16];
      logic [NC-1:0] cc[16];

      bus.i_valid       = 1'b0;
      bus.i_ready       = 1'b1;
      bus.i_final_sum   = '0;
      bus.i_final_carry = '0;

      // Reset state
      #2 rst = 1'b1;
      #1;
      chk("reset_o_valid", 64'(bus.o_valid), 64'd0);
      chk("reset_o_ready", 64'(bus.o_ready), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Directed vectors
      send(48'h0000_00FF_FFFF, 48'h0000_0000_0001);
      send(48'h9000_0000_0000, 48'h0);
      send(48'h8000_0000_0000, 48'h1);
      send(48'hFFFF_FFFF_FFFF, 48'h1);
      drain();

      // Streaming with backpressure on cycles 4..7
      for (int i = 0; i < 16; i++) begin
         ss[i] = rnd_row();
         cc[i] = rnd_row();
      end
      idx = 0;
      cyc = 0;
      bus.i_valid       = 1'b1;
      bus.i_final_sum   = ss[0];
      bus.i_final_carry = cc[0];
      while (idx < 16 && cyc < 200) begin
         bus.i_ready = !(cyc >= 4 && cyc <= 7);
         step(acc);
         cyc++;
         if (acc) begin
            idx++;
            if (idx < 16) begin
               bus.i_final_sum   = ss[idx];
               bus.i_final_carry = cc[idx];
            end
         end
      end
      chk("stream_sent", 64'(idx), 64'd16);
      drain();

      // Reset with two results in flight
      send(rnd_row(), rnd_row());
      send(rnd_row(), rnd_row());
      rst = 1'b1;
      #1;
      chk("midreset_o_valid", 64'(bus.o_valid), 64'd0);
      chk("midreset_o_ready", 64'(bus.o_ready), 64'd1);
      q.delete();
      bus.i_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      r0 = results;
      send(48'h1234_5678_9ABC, 48'h0FED_CBA9_8765);
      bus.i_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         if (bus.o_valid) begin
            seen = 1;
            break;
         end
      end
      chk("post_reset_latency", 64'(seen), 64'd1);
      drain();
      chk("post_reset_count", 64'(results - r0), 64'd1);

      // Random regression with random valid/ready
      accepted = 0;
      cyc = 0;
      bus.i_valid = 1'b0;
      while (accepted < 10000 && cyc < 40000) begin
         if (!bus.i_valid) begin
            bus.i_valid = ($urandom_range(0, 3) != 0);
            bus.i_final_sum   = rnd_row();
            bus.i_final_carry = rnd_row();
         end
         bus.i_ready = ($urandom_range(0, 3) != 0);
         step(acc);
         cyc++;
         if (acc) begin
            accepted++;
            bus.i_valid = 1'b0;
         end
      end
      chk("random_accepted", 64'(accepted), 64'd10000);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
